shift_seq: RTL and testbench

Multi-cycle shift sequencer: accepts a word and a shift amount over a valid/ready handshake, then shifts one bit per clock. The supported shifts are left, logical right and arithmetic right. The result is returned over a second valid/ready handshake. It owns the shift-register datapath and its mode encoding (00 hold, 01 left, 10 right, 11 load), and exports the current mode for observability. It is the shift unit used by the ALU/controller, which must not stall on a combinational barrel shifter.

---
 rtl/shift_seq.sv | 64 ++++++
 tb/tb_shift_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/shift_seq.sv
// shift_seq: multi-cycle one-bit-per-clock shift sequencer (left, logical right, arithmetic right)
// Ports: clk/r clock and sync active-high reset; in_valid/in_ready request handshake carrying
// data_in, amt, dir (0 left, 1 right), arith (MSB fill on right shifts); out_valid/out_ready
// result handshake with data_out; busy in SHIFT/DONE; sel datapath mode (00 hold, 01 left, 10 right, 11 load).
module shift_seq #(
    parameter int size      = 32,
    parameter int amt_width = 5
) (
    input  logic                 clk,
    input  logic                 r,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [size-1:0]      data_in,
    input  logic [amt_width-1:0] amt,
    input  logic                 dir,
    input  logic                 arith,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [size-1:0]      data_out,
    output logic                 busy,
    output logic [1:0]           sel
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t               state;
    logic [size-1:0]      q;
    logic [amt_width-1:0] cnt;
    logic                 dir_q;
    logic                 arith_q;
    // Outputs are forced quiet while r is high, even if the state has not yet been cleared.
    assign in_ready  = state == IDLE && !r;
    assign out_valid = state == DONE && !r;
    assign busy      = state != IDLE && !r;
    assign data_out  = q;
    assign sel       = r ? 2'b00 :
                       (state == IDLE && in_valid) ? 2'b11 :
                       state == SHIFT ? (dir_q ? 2'b10 : 2'b01) : 2'b00;
    always_ff @(posedge clk) begin
        if (r) begin
            state   <= IDLE;
            q       <= '0;
            cnt     <= '0;
            dir_q   <= 1'b0;
            arith_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    q       <= data_in;
                    cnt     <= amt;
                    dir_q   <= dir;
                    arith_q <= arith;
                    state   <= amt != '0 ? SHIFT : DONE;
                end
                SHIFT: begin
                    // The MSB never changes during an arithmetic right shift, so q's MSB is the operand MSB.
                    q     <= dir_q ? {q[size-1] & arith_q, q[size-1:1]} : {q[size-2:0], 1'b0};
                    cnt   <= cnt - 1'b1;
                    state <= cnt == 1 ? DONE : SHIFT;
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_seq.sv
// tb_shift_seq: self-checking bench for shift_seq using a vector table, random vectors and a result queue
module tb_shift_seq;
    logic        clk = 1'b0;
    logic        r = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] data_in = '0;
    logic [4:0]  amt = '0;
    logic        dir = 1'b0;
    logic        arith = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] data_out;
    logic        busy;
    logic [1:0]  sel;
    int checks = 0;
    int failures = 0;
    logic [31:0] sb[$];
    typedef struct {
        logic [31:0] d;
        logic [4:0]  a;
        logic        dr;
        logic        ar;
        logic [31:0] e;
    } vec_t;
    vec_t vecs[9];
    shift_seq dut (
        .clk(clk), .r(r), .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
        .amt(amt), .dir(dir), .arith(arith), .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .busy(busy), .sel(sel)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic accept(input logic [31:0] d, input logic [4:0] a, input logic dr, input logic ar,
                          input logic [31:0] e);
        in_valid = 1'b1;
        data_in  = d;
        amt      = a;
        dir      = dr;
        arith    = ar;
        #1;
        chk("in_ready_idle", 32'(in_ready), 1);
        chk("sel_load", 32'(sel), 3);
        tick;
        in_valid = 1'b0;
        sb.push_back(e);
    endtask
    task automatic await_result(input int n, input logic dr);
        int k = 1;
        logic [31:0] e;
        forever begin
            #1;
            if (out_valid === 1'b1) break;
            chk("sel_shift", 32'(sel), dr ? 2 : 1);
            chk("in_ready_busy", 32'(in_ready), 0);
            chk("busy_shift", 32'(busy), 1);
            if (k > n + 4) begin
                chk("timeout", 0, 1);
                break;
            end
            tick;
            k++;
        end
        chk("latency", 32'(k), 32'(n + 1));
        chk("sel_done", 32'(sel), 0);
        chk("busy_done", 32'(busy), 1);
        chk("in_ready_done", 32'(in_ready), 0);
        e = sb.pop_front();
        chk("data_out", data_out, e);
    endtask
    task automatic do_op(input logic [31:0] d, input logic [4:0] a, input logic dr, input logic ar,
                         input logic [31:0] e);
        accept(d, a, dr, ar, e);
        await_result(int'(a), dr);
        tick;
        chk("out_valid_drop", 32'(out_valid), 0);
        chk("in_ready_back", 32'(in_ready), 1);
    endtask
    initial begin
        logic [31:0] d, e, held;
        logic [4:0]  a;
        logic        dr, ar;
        int          seen;
        vecs[0] = '{32'h000000F0, 5'd4,  1'b0, 1'b0, 32'h00000F00};
        vecs[1] = '{32'h80000000, 5'd31, 1'b1, 1'b1, 32'hFFFFFFFF};
        vecs[2] = '{32'h80000000, 5'd31, 1'b1, 1'b0, 32'h00000001};
        vecs[3] = '{32'hDEADBEEF, 5'd0,  1'b0, 1'b0, 32'hDEADBEEF};
        vecs[4] = '{32'hDEADBEEF, 5'd0,  1'b1, 1'b1, 32'hDEADBEEF};
        vecs[5] = '{32'h12345678, 5'd8,  1'b1, 1'b0, 32'h00123456};
        vecs[6] = '{32'h87654321, 5'd4,  1'b1, 1'b1, 32'hF8765432};
        vecs[7] = '{32'h00000001, 5'd31, 1'b0, 1'b0, 32'h80000000};
        vecs[8] = '{32'hA5A5A5A5, 5'd1,  1'b0, 1'b1, 32'h4B4B4B4A};
        tick;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_busy", 32'(busy), 0);
        in_valid = 1'b1;
        #1;
        chk("rst_sel", 32'(sel), 0);
        tick;
        chk("rst_in_ready2", 32'(in_ready), 0);
        chk("rst_data_out2", data_out, 0);
        r = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("in_ready_after_rst", 32'(in_ready), 1);
        chk("sel_idle", 32'(sel), 0);
        foreach (vecs[i]) do_op(vecs[i].d, vecs[i].a, vecs[i].dr, vecs[i].ar, vecs[i].e);
        for (int i = 0; i < 6; i++) begin
            d  = $urandom;
            a  = 5'($urandom_range(0, 31));
            dr = 1'($urandom_range(0, 1));
            ar = 1'($urandom_range(0, 1));
            e  = dr ? (ar ? 32'($signed(d) >>> a) : d >> a) : d << a;
            do_op(d, a, dr, ar, e);
        end
        accept(32'h00000001, 5'd3, 1'b0, 1'b0, 32'h00000008);
        in_valid  = 1'b1;
        data_in   = 32'h0000FFFF;
        amt       = 5'd0;
        out_ready = 1'b0;
        await_result(3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("hold_out_valid", 32'(out_valid), 1);
            chk("hold_data_out", data_out, 32'h00000008);
            chk("hold_in_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        tick;
        chk("late_accept_ready", 32'(in_ready), 1);
        chk("late_accept_sel", 32'(sel), 3);
        sb.push_back(32'h0000FFFF);
        tick;
        in_valid = 1'b0;
        await_result(0, 1'b0);
        tick;
        held = 32'h00000400;
        in_valid = 1'b1;
        data_in  = 32'h00000001;
        amt      = 5'd10;
        dir      = 1'b0;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        chk("mid_data", data_out, 32'h00000004);
        chk("mid_busy", 32'(busy), 1);
        r = 1'b1;
        #1;
        chk("mid_rst_sel", 32'(sel), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_in_ready", 32'(in_ready), 0);
        tick;
        r = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 1);
        chk("post_rst_data", data_out, 0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid === 1'b1 || data_out === held) seen++;
            tick;
        end
        chk("abandoned_no_valid", 32'(seen), 0);
        do_op(32'h00000001, 5'd3, 1'b0, 1'b0, 32'h00000008);
        chk("sb_empty", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
